bcd_scan_counter: RTL and testbench

Multi-digit BCD up/down counter with an integrated display scanner, directly upstream of the 7-segment decoder. Steps the count on a prescaled tick. Time-multiplexes one 4-bit BCD digit at a time onto `digit`, which drives the decoder input, with a matching active-low anode strobe for common-anode displays.

---
 rtl/bcd_scan_counter.sv | 177 +++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter
// ----------------------------------------------------------------------------
// Multi-digit BCD up/down counter with an integrated display scanner that feeds
// a 7-segment decoder. The count steps once every TICK_DIV enabled clocks; the
// scanner presents one digit per SCAN_DIV clocks on `digit` together with an
// active-low anode strobe for common-anode displays.
//
// Optional feature (compile-time macro): LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (never digit 0) are emitted as 4'hF,
//   which the downstream decoder renders blank. When undefined, every digit
//   is emitted as its BCD value.
//
// Parameters:
//   NUM_DIGITS  number of BCD digits counted and scanned (1..8)
//   TICK_DIV    clk cycles per count step (>=2)
//   SCAN_DIV    clk cycles per scan slot (>=2)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         count enable; low freezes count and tick prescaler
//   up_dn      1 = count up, 0 = count down
//   clear      synchronous clear of count and tick prescaler (highest priority)
//   load       synchronous parallel load of load_val (nibbles >9 load as 0)
//   load_val   BCD load value, digit 0 in [3:0]
//   digit      BCD digit currently scanned
//   anode      one-hot-low digit select, anode[0] = least significant digit
//   count_bcd  full registered count
//   wrap       one-cycle pulse on roll-over / roll-under
// ----------------------------------------------------------------------------
module bcd_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [3:0]              digit,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap
);

  localparam int CW     = 4 * NUM_DIGITS;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [SCAN_W-1:0]   scan_cnt_reg;
  logic [IDX_W-1:0]    scan_idx_reg;
  logic [CW-1:0]       count_reg;
  logic                wrap_reg;
  logic [3:0]          digit_reg;
  logic [NUM_DIGITS-1:0] anode_reg;

  logic                tick;
  logic [CW-1:0]       step_next;
  logic [CW-1:0]       load_clean;
  // carry[i] = digit i must move; carry[NUM_DIGITS] = whole count rolled.
  // The same chain serves as carry (up) and borrow (down).
  logic [NUM_DIGITS:0] carry;
  logic [3:0]          digs [NUM_DIGITS];
  logic [3:0]          digit_next;

  assign tick     = en && (tick_cnt_reg == TICK_W'(TICK_DIV - 1));
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] d_cur;
      logic       at_edge;
      logic [3:0] ld_nib;

      assign d_cur        = count_reg[gi*4 +: 4];
      assign digs[gi]     = d_cur;
      // Digit that wraps (9 going up, 0 going down) passes the carry along.
      assign at_edge      = up_dn ? (d_cur == 4'd9) : (d_cur == 4'd0);
      assign carry[gi+1]  = carry[gi] & at_edge;
      assign step_next[gi*4 +: 4] =
          !carry[gi] ? d_cur :
          at_edge    ? (up_dn ? 4'd0 : 4'd9) :
          up_dn      ? d_cur + 4'd1 : d_cur - 4'd1;

      assign ld_nib = load_val[gi*4 +: 4];
      assign load_clean[gi*4 +: 4] = (ld_nib > 4'd9) ? 4'd0 : ld_nib;
    end
  endgenerate

  // Count path and tick prescaler: clear > load > tick step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      tick_cnt_reg <= '0;
      wrap_reg     <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (clear) begin
        count_reg    <= '0;
        tick_cnt_reg <= '0;
      end else if (load) begin
        count_reg    <= load_clean;
        tick_cnt_reg <= '0;
      end else if (en) begin
        if (tick) begin
          tick_cnt_reg <= '0;
          count_reg    <= step_next;
          wrap_reg     <= carry[NUM_DIGITS];
        end else begin
          tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
        end
      end
    end
  end

  // Scan prescaler and index run freely, unaffected by en/clear/load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= '0;
    end else if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= (scan_idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                               : scan_idx_reg + IDX_W'(1);
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lz[i] = digits i..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS-1:0] lz;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign lz[gi] = (digs[gi] == 4'd0);
      end else begin : g_mid
        assign lz[gi] = (digs[gi] == 4'd0) & lz[gi+1];
      end
    end
  endgenerate

  always_comb begin
    digit_next = digs[scan_idx_reg];
    if (scan_idx_reg != '0 && lz[scan_idx_reg]) begin
      digit_next = 4'hF;
    end
  end
`else
  always_comb begin
    digit_next = digs[scan_idx_reg];
  end
`endif

  // anode and digit come from the same index on the same edge, so a new
  // strobe never shows the previous slot's digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_reg <= ~NUM_DIGITS'(1);
      digit_reg <= 4'd0;
    end else begin
      anode_reg <= ~(NUM_DIGITS'(1) << scan_idx_reg);
      digit_reg <= digit_next;
    end
  end

  assign count_bcd = count_reg;
  assign wrap      = wrap_reg;
  assign digit     = digit_reg;
  assign anode     = anode_reg;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Testbench for bcd_scan_counter (NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2).
// A decimal-integer reference model predicts count, wrap, anode and digit for
// every clock; predictions are queued when inputs are driven and compared
// after the following rising edge.
module tb_bcd_scan_counter;

  localparam int ND = 4;
  localparam int TD = 4;
  localparam int SD = 2;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic [3:0]  digit;
  logic [3:0]  anode;
  logic [15:0] count_bcd;
  logic        wrap;

  bcd_scan_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val), .digit(digit), .anode(anode),
    .count_bcd(count_bcd), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    logic        w;
    logic [3:0]  an;
    logic [3:0]  dg;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // reference model state
  int cnt_m, tick_m, scnt_m, idx_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] b);
    int v, p;
    logic [3:0] nib;
    v = 0;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      nib = b[i*4 +: 4];
      if (nib <= 4'd9) v += int'(nib) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_digit(input int c, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p *= 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && (c / p) == 0) return 4'hF;
`endif
    return 4'((c / p) % 10);
  endfunction

  task automatic model_reset();
    cnt_m  = 0;
    tick_m = 0;
    scnt_m = 0;
    idx_m  = 0;
  endtask

  // Drive one cycle of inputs, queue the prediction, compare after the edge.
  task automatic step(input logic en_i, input logic up_i, input logic clr_i,
                      input logic ld_i, input logic [15:0] lv);
    exp_t e, g;
    en = en_i; up_dn = up_i; clear = clr_i; load = ld_i; load_val = lv;
    e.an = ~(4'(1) << idx_m);
    e.dg = exp_digit(cnt_m, idx_m);
    e.w  = 1'b0;
    if (clr_i) begin
      cnt_m = 0; tick_m = 0;
    end else if (ld_i) begin
      cnt_m = from_load(lv); tick_m = 0;
    end else if (en_i) begin
      if (tick_m == TD - 1) begin
        tick_m = 0;
        if (up_i) begin
          if (cnt_m == MAXV) begin cnt_m = 0; e.w = 1'b1; end
          else cnt_m++;
        end else begin
          if (cnt_m == 0) begin cnt_m = MAXV; e.w = 1'b1; end
          else cnt_m--;
        end
      end else begin
        tick_m++;
      end
    end
    if (scnt_m == SD - 1) begin
      scnt_m = 0;
      idx_m  = (idx_m + 1) % ND;
    end else begin
      scnt_m++;
    end
    e.cnt = to_bcd(cnt_m);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      check_eq("count", count_bcd, g.cnt);
      check_eq("wrap", wrap, g.w);
      check_eq("anode", anode, g.an);
      check_eq("digit", digit, g.dg);
    end
  endtask

  initial begin
    int guard;
    model_reset();
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_count", count_bcd, 16'h0000);
    check_eq("rst_wrap", wrap, 1'b0);
    check_eq("rst_anode", anode, 4'b1110);
    check_eq("rst_digit", digit, 4'd0);
    rst_n = 1'b1;

    // 1: count up 10 ticks
    repeat (40) step(1, 1, 0, 0, 16'h0);
    check_eq("t1_count", count_bcd, 16'h0010);

    // 2: roll-over 9999 -> 0000
    step(1, 1, 0, 1, 16'h9998);
    repeat (8) step(1, 1, 0, 0, 16'h0);
    check_eq("t2_count", count_bcd, 16'h0000);
    check_eq("t2_wrap", wrap, 1'b1);
    step(1, 1, 0, 0, 16'h0);

    // 3: roll-under 0000 -> 9999, then load with invalid nibbles
    step(1, 0, 0, 1, 16'h0000);
    repeat (4) step(1, 0, 0, 0, 16'h0);
    check_eq("t3_count", count_bcd, 16'h9999);
    check_eq("t3_wrap", wrap, 1'b1);
    step(1, 0, 0, 1, 16'h12AF);
    check_eq("t3_load", count_bcd, 16'h1200);

    // borrow / carry ripple across several digits
    step(1, 0, 0, 1, 16'h1000);
    repeat (4) step(1, 0, 0, 0, 16'h0);
    check_eq("borrow", count_bcd, 16'h0999);
    step(1, 1, 0, 1, 16'h0999);
    repeat (4) step(1, 1, 0, 0, 16'h0);
    check_eq("carry", count_bcd, 16'h1000);

    // 4: clear+load on a tick cycle, then load alone on a tick cycle
    step(1, 1, 0, 1, 16'h9999);
    guard = 0;
    while (tick_m != TD - 1 && guard < 2 * TD) begin
      step(1, 1, 0, 0, 16'h0);
      guard++;
    end
    step(1, 1, 1, 1, 16'h5555);
    check_eq("t4_clr", count_bcd, 16'h0000);
    check_eq("t4_nowrap", wrap, 1'b0);
    step(1, 1, 0, 1, 16'h9999);
    repeat (TD - 1) step(1, 1, 0, 0, 16'h0);
    step(1, 1, 0, 1, 16'h0042);
    check_eq("t4_ld", count_bcd, 16'h0042);
    check_eq("t4_ld_nowrap", wrap, 1'b0);
    repeat (20) step(0, 1, 0, 0, 16'h0);
    check_eq("t4_frozen", count_bcd, 16'h0042);

    // 5: scan pattern with count 4321
    step(0, 1, 0, 1, 16'h4321);
    repeat (10) step(0, 1, 0, 0, 16'h0);

    // 6: leading-zero patterns, then reset mid-scan
    step(0, 1, 0, 1, 16'h0050);
    repeat (8) step(0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 1, 16'h0000);
    repeat (8) step(0, 1, 0, 0, 16'h0);
    step(1, 1, 0, 1, 16'h0321);
    repeat (3) step(1, 1, 0, 0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_anode", anode, 4'b1110);
    check_eq("mid_rst_digit", digit, 4'd0);
    check_eq("mid_rst_count", count_bcd, 16'h0000);
    check_eq("mid_rst_wrap", wrap, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // first tick lands TICK_DIV cycles after release
    repeat (TD - 1) step(1, 1, 0, 0, 16'h0);
    check_eq("rel_no_tick", count_bcd, 16'h0000);
    step(1, 1, 0, 0, 16'h0);
    check_eq("rel_tick", count_bcd, 16'h0001);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
